// File: rtl/divdr_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } divdr_state_e;

  localparam int unsigned DIVDR_DEFAULT_N = 4;
  localparam int unsigned DIVDR_CNT_W     = $clog2(DIVDR_DEFAULT_N + 1);

  // Step-counter width for an arbitrary operand width.
  function automatic int unsigned divdr_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift, trial subtract, restore.
module restoring_div_step #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_rem,
  input  logic [N-1:0] i_quo,
  input  logic [N-1:0] i_div,
  output logic [N-1:0] o_rem,
  output logic [N-1:0] o_quo
);

  logic [N:0]   w_shift;
  logic [N-1:0] w_diff;
  logic         w_ge;

  // The trial value is N+1 bits; when it is kept, its top bit is always zero
  // because the incoming remainder is smaller than the divisor.
  always_comb begin
    w_shift = {i_rem, i_quo[N-1]};
    w_ge    = (w_shift >= {1'b0, i_div});
    w_diff  = w_shift[N-1:0] - i_div;
    o_rem   = w_ge ? w_diff : w_shift[N-1:0];
    o_quo   = {i_quo[N-2:0], w_ge};
  end

endmodule

// File: rtl/seq_restoring_divdr.sv
// Sequential N-bit restoring divider with start/done handshake.
// Define DIVDR_SIGNED_EN for two's-complement operands (adds a sign-fixup cycle).
module seq_restoring_divdr
  import divdr_pkg::*;
#(
  parameter int unsigned N = DIVDR_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = divdr_cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  divdr_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;

  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_q_nxt;
  logic [N-1:0]  w_dvd_mag;
  logic [N-1:0]  w_dvs_mag;

`ifdef DIVDR_SIGNED_EN
  logic r_dvd_neg;
  logic r_dvs_neg;

  // The most-negative value's magnitude still fits in N unsigned bits.
  always_comb begin
    w_dvd_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    w_dvs_mag = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
  end
`else
  always_comb begin
    w_dvd_mag = dividend;
    w_dvs_mag = divisor;
  end
`endif

  restoring_div_step #(.N(N)) u_step (
    .i_rem (r_rem),
    .i_quo (r_q),
    .i_div (r_d),
    .o_rem (w_rem_nxt),
    .o_quo (w_q_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
`ifdef DIVDR_SIGNED_EN
      r_dvd_neg   <= 1'b0;
      r_dvs_neg   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_d     <= w_dvs_mag;
              r_q     <= w_dvd_mag;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
`ifdef DIVDR_SIGNED_EN
              r_dvd_neg <= dividend[N-1];
              r_dvs_neg <= divisor[N-1];
`endif
            end
          end else if (r_state == DONE) begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_q   <= w_q_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt == LAST_STEP) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
`ifdef DIVDR_SIGNED_EN
            r_state <= FIXUP;
`else
            r_quotient  <= w_q_nxt;
            r_remainder <= w_rem_nxt;
            r_done      <= 1'b1;
            r_state     <= DONE;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef DIVDR_SIGNED_EN
        // Truncation toward zero: remainder follows the dividend's sign.
        FIXUP: begin
          r_quotient  <= (r_dvd_neg ^ r_dvs_neg) ? (~r_q + 1'b1) : r_q;
          r_remainder <= r_dvd_neg ? (~r_rem + 1'b1) : r_rem;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
`else
        FIXUP: r_state <= IDLE;
`endif

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divdr.sv
// Self-checking bench for seq_restoring_divdr (N=4), unsigned or DIVDR_SIGNED_EN build.
module tb_seq_restoring_divdr;

  localparam int unsigned N = 4;
`ifdef DIVDR_SIGNED_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  seq_restoring_divdr #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic z);
`ifdef DIVDR_SIGNED_EN
    int sa;
    int sb;
    int sq;
    int sr;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = 4'hF; r = a; z = 1'b1;
    end else if (sa == -8 && sb == -1) begin
      q = 4'h8; r = 4'h0; z = 1'b0;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q = sq[3:0]; r = sr[3:0]; z = 1'b0;
    end
`else
    int ua;
    int ub;
    int uq;
    int ur;
    ua = int'(a);
    ub = int'(b);
    if (ub == 0) begin
      q = 4'hF; r = a; z = 1'b1;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      q = uq[3:0]; r = ur[3:0]; z = 1'b0;
    end
`endif
  endfunction

  // Issue one operation and check latency, busy profile and results.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez,
                        input bit glitch, input string nm);
    int  cyc;
    int  exp_lat;
    bit  busy_ok;
    exp_lat = ez ? 0 : int'(N + EXTRA);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 4'($urandom_range(15));
    divisor  = 4'($urandom_range(15));
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== ((!ez && cyc < int'(N)) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (glitch && cyc == 1) begin
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    check({nm, " busy_profile"}, {31'd0, busy_ok}, 32'd1);
    check({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({nm, " quotient"}, {28'd0, quotient}, {28'd0, eq});
    check({nm, " remainder"}, {28'd0, remainder}, {28'd0, er});
    check({nm, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [3:0] eq;
    logic [3:0] er;
    logic       ez;
    bit         done_seen;

`ifdef DIVDR_SIGNED_EN
    tbl[0] = '{a: 4'h9, b: 4'h2, q: 4'hD, r: 4'hF, z: 1'b0}; // -7/2
    tbl[1] = '{a: 4'h8, b: 4'hF, q: 4'h8, r: 4'h0, z: 1'b0}; // -8/-1
    tbl[2] = '{a: 4'h7, b: 4'hE, q: 4'hD, r: 4'h1, z: 1'b0}; // 7/-2
    tbl[3] = '{a: 4'hD, b: 4'h4, q: 4'h0, r: 4'hD, z: 1'b0}; // -3/4
    tbl[4] = '{a: 4'h7, b: 4'h0, q: 4'hF, r: 4'h7, z: 1'b1};
    tbl[5] = '{a: 4'h6, b: 4'h3, q: 4'h2, r: 4'h0, z: 1'b0};
`else
    tbl[0] = '{a: 4'd13, b: 4'd4, q: 4'd3,  r: 4'd1, z: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0};
    tbl[2] = '{a: 4'd3,  b: 4'd7, q: 4'd0,  r: 4'd3, z: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0, z: 1'b0};
    tbl[4] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, z: 1'b1};
    tbl[5] = '{a: 4'd9,  b: 4'd3, q: 4'd3,  r: 4'd0, z: 1'b0};
`endif

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", {28'd0, quotient}, 32'd0);
    check("reset remainder", {28'd0, remainder}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0,
             $sformatf("table%0d", i));
    end

    // Results must hold through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("hold done", {31'd0, done}, 32'd0);
    check("hold quotient", {28'd0, quotient}, {28'd0, tbl[5].q});
    check("hold remainder", {28'd0, remainder}, {28'd0, tbl[5].r});

    // Start pulsed while busy with different operands is ignored.
    model(4'd13, 4'd4, eq, er, ez);
    run_op(4'd13, 4'd4, eq, er, ez, 1'b1, "ignore_start");

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst quotient", {28'd0, quotient}, 32'd0);
    check("midrst remainder", {28'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    check("midrst no_done", {31'd0, done_seen}, 32'd0);
    model(4'd14, 4'd3, eq, er, ez);
    run_op(4'd14, 4'd3, eq, er, ez, 1'b0, "after_rst");

    // Exhaustive sweep against the reference model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        model(4'(a), 4'(b), eq, er, ez);
        run_op(4'(a), 4'(b), eq, er, ez, 1'b0, $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    // Random back-to-back operations, some with a start glitch while busy.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      bit         g;
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      g  = 1'($urandom_range(1));
      model(ra, rb, eq, er, ez);
      run_op(ra, rb, eq, er, ez, g, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
